// File: rtl/riscv_wb_pkg.sv
// Writeback stage shared types: load funct3 codes and FSM states.
// Imported by load_unit and writeback.
package riscv_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_t;

endpackage

// File: rtl/load_unit.sv
// Load data alignment and extension; flags misaligned and illegal loads.
// Purely combinational, mirrors the store-side lane steering.
module load_unit
  import riscv_wb_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign shifted  = mem_rdata >> {offset, 3'b000};
  assign byte_val = shifted[7:0];
  assign half_val = offset[1] ? mem_rdata[31:16]
                              : mem_rdata[15:0];

  always_comb begin
    load_data  = 32'd0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB):
        load_data = {{24{byte_val[7]}}, byte_val};
      (funct3 == F3_LBU):
        load_data = {24'd0, byte_val};
      (funct3 == F3_LH): begin
        load_data  = {{16{half_val[15]}}, half_val};
        misaligned = offset[0];
      end
      (funct3 == F3_LHU): begin
        load_data  = {16'd0, half_val};
        misaligned = offset[0];
      end
      (funct3 == F3_LW): begin
        load_data  = mem_rdata;
        misaligned = (offset != 2'b00);
      end
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: completes loads, drives the register-file port,
// stalls upstream while a load response is outstanding.
module writeback
  import riscv_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_from_memory,
  input  logic [2:0]  funct3_from_memory,
  input  logic [4:0]  rd_from_memory,
  input  logic        write_reg_from_memory,
  input  logic        select_from_memory,
  input  logic        read_from_memory,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_addr,
  output logic [31:0] reg_write_data,
  output logic        stall_pipeline,
  output logic        load_fault
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  wb_state_t   state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  cap_f3, cap_f3_n;
  logic [4:0]  cap_rd, cap_rd_n;
  logic        cap_wr, cap_wr_n;
  logic [1:0]  cap_off, cap_off_n;

  logic        en_n, fault_n;
  logic [4:0]  addr_n;
  logic [31:0] data_n;

  logic        waiting, is_load;
  logic [2:0]  c_f3;
  logic [4:0]  c_rd;
  logic        c_wr;
  logic [1:0]  c_off;
  logic [31:0] ld_data;
  logic        ld_mis, ld_ill;

  assign waiting        = (state == WAIT_LOAD);
  assign stall_pipeline = waiting;
  assign is_load = select_from_memory && read_from_memory;

  // In WAIT_LOAD the upstream fields are stale; use the captured copy.
  assign c_f3  = waiting ? cap_f3  : funct3_from_memory;
  assign c_rd  = waiting ? cap_rd  : rd_from_memory;
  assign c_wr  = waiting ? cap_wr  : write_reg_from_memory;
  assign c_off = waiting ? cap_off : result_from_memory[1:0];

  load_unit u_load (
    .mem_rdata  (mem_rdata),
    .funct3     (c_f3),
    .offset     (c_off),
    .load_data  (ld_data),
    .misaligned (ld_mis),
    .illegal    (ld_ill)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cap_f3_n  = cap_f3;
    cap_rd_n  = cap_rd;
    cap_wr_n  = cap_wr;
    cap_off_n = cap_off;
    en_n      = 1'b0;
    fault_n   = 1'b0;
    addr_n    = reg_write_addr;
    data_n    = reg_write_data;
    unique case (state)
      IDLE: begin
        if (!is_load) begin
          en_n   = write_reg_from_memory &&
                   (rd_from_memory != 5'd0);
          addr_n = rd_from_memory;
          data_n = result_from_memory;
        end else if (!mem_rvalid) begin
          cap_f3_n  = funct3_from_memory;
          cap_rd_n  = rd_from_memory;
          cap_wr_n  = write_reg_from_memory;
          cap_off_n = result_from_memory[1:0];
          cnt_n     = 8'd0;
          state_n   = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        cnt_n = cnt + 8'd1;
        if (mem_rvalid) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          fault_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if ((is_load || waiting) && mem_rvalid) begin
      if (ld_mis || ld_ill) begin
        fault_n = 1'b1;
      end else begin
        en_n   = c_wr && (c_rd != 5'd0);
        addr_n = c_rd;
        data_n = ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      cap_f3         <= 3'd0;
      cap_rd         <= 5'd0;
      cap_wr         <= 1'b0;
      cap_off        <= 2'd0;
      reg_write_en   <= 1'b0;
      reg_write_addr <= 5'd0;
      reg_write_data <= 32'd0;
      load_fault     <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      cap_f3         <= cap_f3_n;
      cap_rd         <= cap_rd_n;
      cap_wr         <= cap_wr_n;
      cap_off        <= cap_off_n;
      reg_write_en   <= en_n;
      reg_write_addr <= addr_n;
      reg_write_data <= data_n;
      load_fault     <= fault_n;
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage.
// Timeout shortened to 4 cycles.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] result = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic        wr = 1'b0;
  logic        sel = 1'b0;
  logic        rdn = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        rvalid = 1'b0;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        stall;
  logic        fault;

  int checks = 0;
  int errors = 0;

  writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .result_from_memory    (result),
    .funct3_from_memory    (funct3),
    .rd_from_memory        (rd),
    .write_reg_from_memory (wr),
    .select_from_memory    (sel),
    .read_from_memory      (rdn),
    .mem_rdata             (rdata),
    .mem_rvalid            (rvalid),
    .reg_write_en          (en),
    .reg_write_addr        (addr),
    .reg_write_data        (data),
    .stall_pipeline        (stall),
    .load_fault            (fault)
  );

  always #5 clk = ~clk;

  task automatic drive(
    input logic [31:0] r, input logic [2:0] f,
    input logic [4:0] d, input logic w,
    input logic s, input logic rr,
    input logic [31:0] md, input logic mv);
    result = r; funct3 = f; rd = d; wr = w;
    sel = s; rdn = rr; rdata = md; rvalid = mv;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({en, addr, data, stall, fault} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {en, addr, data, stall, fault});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(32'h0000_1234, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0,
          32'hDEAD_BEEF, 1'b1);
    edge_sample();
    checks++;
    if ({en, addr, data, stall} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
      errors++;
      $display("FAIL alu_write got en=%b addr=%0d data=%h stall=%b want 1/5/00001234/0",
               en, addr, data, stall);
    end
  endtask

  task automatic test_lb_zero_wait();
    @(negedge clk);
    drive(32'h0000_1002, 3'b000, 5'd7, 1'b1, 1'b1, 1'b1,
          32'h0080_0000, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lb_nostall got %b want 0", stall);
    end
    edge_sample();
    checks++;
    if ({en, addr, data} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
      errors++;
      $display("FAIL lb_data got en=%b addr=%0d data=%h want 1/7/ffffff80",
               en, addr, data);
    end
  endtask

  task automatic test_lh_sign();
    @(negedge clk);
    drive(32'h0000_0002, 3'b001, 5'd8, 1'b1, 1'b1, 1'b1,
          32'h8001_1234, 1'b1);
    edge_sample();
    checks++;
    if ({en, addr, data, fault} !== {1'b1, 5'd8, 32'hFFFF_8001, 1'b0}) begin
      errors++;
      $display("FAIL lh_sign got en=%b addr=%0d data=%h fault=%b want 1/8/ffff8001/0",
               en, addr, data, fault);
    end
  endtask

  task automatic test_lhu_wait();
    int stalled;
    int wrote;
    stalled = 0;
    wrote = 0;
    @(negedge clk);
    drive(32'h0000_2002, 3'b101, 5'd9, 1'b1, 1'b1, 1'b1,
          32'h0, 1'b0);
    edge_sample();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // Upstream garbage must not disturb the captured load.
      drive(32'hFFFF_FFFF, 3'b011, 5'd3, 1'b0, 1'b0, 1'b0,
            (i == 2) ? 32'hBEEF_0000 : 32'h1111_1111, i == 2);
      if (stall) stalled++;
      if (en) wrote++;
    end
    edge_sample();
    checks++;
    if (stalled !== 3 || wrote !== 0) begin
      errors++;
      $display("FAIL lhu_stall got stalled=%0d wrote=%0d want 3/0",
               stalled, wrote);
    end
    checks++;
    if ({en, addr, data, stall} !== {1'b1, 5'd9, 32'h0000_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL lhu_data got en=%b addr=%0d data=%h stall=%b want 1/9/0000beef/0",
               en, addr, data, stall);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    int wrote;
    cycles = 0;
    wrote = 0;
    @(negedge clk);
    drive(32'h0000_3000, 3'b010, 5'd10, 1'b1, 1'b1, 1'b1,
          32'h0, 1'b0);
    edge_sample();
    while (stall && cycles < 10) begin
      edge_sample();
      cycles++;
      if (en) wrote++;
    end
    checks++;
    if (cycles !== 4 || wrote !== 0 || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout got cycles=%0d wrote=%0d fault=%b want 4/0/1",
               cycles, wrote, fault);
    end
    drive(32'h0000_0055, 3'd0, 5'd11, 1'b1, 1'b0, 1'b0,
          32'hCAFE_F00D, 1'b1);
    edge_sample();
    checks++;
    if ({en, addr, data, fault, stall} !==
        {1'b1, 5'd11, 32'h55, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_timeout got en=%b addr=%0d data=%h fault=%b stall=%b want 1/11/00000055/0/0",
               en, addr, data, fault, stall);
    end
  endtask

  task automatic test_faults();
    @(negedge clk);
    drive(32'h0000_0001, 3'b010, 5'd12, 1'b1, 1'b1, 1'b1,
          32'h1234_5678, 1'b1);
    edge_sample();
    checks++;
    if ({en, fault} !== 2'b01) begin
      errors++;
      $display("FAIL lw_misaligned got en=%b fault=%b want 0/1", en, fault);
    end
    @(negedge clk);
    drive(32'h0000_0000, 3'b011, 5'd12, 1'b1, 1'b1, 1'b1,
          32'h1234_5678, 1'b1);
    edge_sample();
    checks++;
    if ({en, fault} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_f3 got en=%b fault=%b want 0/1", en, fault);
    end
    @(negedge clk);
    drive(32'h0000_0099, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0,
          32'h0, 1'b0);
    edge_sample();
    checks++;
    if ({en, fault} !== 2'b00) begin
      errors++;
      $display("FAIL alu_x0 got en=%b fault=%b want 0/0", en, fault);
    end
    @(negedge clk);
    drive(32'h0000_0000, 3'b010, 5'd0, 1'b1, 1'b1, 1'b1,
          32'h1234_5678, 1'b1);
    edge_sample();
    checks++;
    if ({en, fault} !== 2'b00) begin
      errors++;
      $display("FAIL lw_x0 got en=%b fault=%b want 0/0", en, fault);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(32'h0000_4003, 3'b100, 5'd13, 1'b1, 1'b1, 1'b1,
          32'h0, 1'b0);
    edge_sample();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry got stall=%b want 1", stall);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({en, addr, data, stall, fault} !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0",
               {en, addr, data, stall, fault});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0000_4003, 3'b100, 5'd14, 1'b1, 1'b1, 1'b1,
          32'hA500_0000, 1'b1);
    edge_sample();
    checks++;
    if ({en, addr, data, stall} !== {1'b1, 5'd14, 32'h0000_00A5, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_lbu got en=%b addr=%0d data=%h stall=%b want 1/14/000000a5/0",
               en, addr, data, stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_zero_wait();
    test_lh_sign();
    test_lhu_wait();
    test_timeout();
    test_faults();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
